range_sequencer: RTL and testbench

RANGE_SEQUENCER -- requirements
Module: range_sequencer

---
 rtl/range_sequencer.sv | 168 ++++++++++++++++
 tb/tb_range_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/range_sequencer.sv
// range_sequencer: ultrasonic-style ranging controller.
// Fires a trigger pulse, then measures the echo pulse width in clk cycles.
// Width and wait are both bounded by a timeout, and a holdoff follows every measurement.
// Optional feature macro: RANGE_AUTO_RETRIGGER_EN. When it is defined, IDLE restarts
// automatically to give continuous ranging, and start is ignored.
module range_sequencer #(
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned HOLDOFF_CYCLES = 3000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        echo,
  output logic        trig,
  output logic [25:0] dist_counter,
  output logic        valid,
  output logic        timeout,
  output logic        busy
);

  localparam int unsigned CW = 26;
  localparam logic [CW-1:0] CNT_SAT  = '1;
  localparam logic [CW-1:0] TRIG_END = CW'(TRIG_CYCLES);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_END = CW'(HOLDOFF_CYCLES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_ECHO = 3'd2,
    MEASURE   = 3'd3,
    HOLDOFF   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] dist_q, dist_d;
  logic          trig_q, trig_d;
  logic          valid_q, valid_d;
  logic          timeout_q, timeout_d;
  logic          busy_q, busy_d;
  logic          sync1_q, echo_s_q, echo_d3_q;

  logic          echo_rise_c;
  logic          echo_fall_c;
  logic          go_c;
  logic [CW-1:0] cnt_inc_c;

  // Echo edges are taken against a third registered copy of the synchronized line
  assign echo_rise_c = echo_s_q & ~echo_d3_q;
  assign echo_fall_c = ~echo_s_q & echo_d3_q;
  assign cnt_inc_c   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);

`ifdef RANGE_AUTO_RETRIGGER_EN
  assign go_c = 1'b1;
`else
  assign go_c = start;
`endif

  // State, counters, outputs and the echo synchronizer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dist_q    <= '0;
      trig_q    <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      sync1_q   <= 1'b0;
      echo_s_q  <= 1'b0;
      echo_d3_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dist_q    <= dist_d;
      trig_q    <= trig_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      sync1_q   <= echo;
      echo_s_q  <= sync1_q;
      echo_d3_q <= echo_s_q;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dist_d    = dist_q;
    trig_d    = 1'b0;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (go_c) begin
          state_d = TRIG;
          cnt_d   = CW'(1);
          trig_d  = 1'b1;
        end
      end
      TRIG: begin
        if (cnt_q >= TRIG_END) begin
          state_d = WAIT_ECHO;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt_inc_c;
          trig_d = 1'b1;
        end
      end
      WAIT_ECHO: begin
        // A rise seen on the entry cycle means echo was already high: ignore it
        if (echo_rise_c && (cnt_q != '0)) begin
          state_d = MEASURE;
          cnt_d   = CW'(1);
        end else if (cnt_q >= TO_LAST) begin
          state_d   = HOLDOFF;
          cnt_d     = CW'(1);
          dist_d    = CNT_SAT;
          timeout_d = 1'b1;
          valid_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end
      MEASURE: begin
        if (echo_fall_c) begin
          state_d   = HOLDOFF;
          cnt_d     = CW'(1);
          dist_d    = cnt_q;
          timeout_d = 1'b0;
          valid_d   = 1'b1;
        end else if (cnt_q >= TO_LAST) begin
          state_d   = HOLDOFF;
          cnt_d     = CW'(1);
          dist_d    = CNT_SAT;
          timeout_d = 1'b1;
          valid_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end
      HOLDOFF: begin
        if (cnt_q >= HOLD_END) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  assign trig         = trig_q;
  assign dist_counter = dist_q;
  assign valid        = valid_q;
  assign timeout      = timeout_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_range_sequencer.sv
// Bench for range_sequencer: randomized echo delays/widths against a pulse-level model.
module tb_range_sequencer;

  localparam int unsigned TRIG_CYCLES    = 4;
  localparam int unsigned TIMEOUT_CYCLES = 100;
  localparam int unsigned HOLDOFF_CYCLES = 10;
  localparam logic [31:0] SAT = 32'h03FF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        echo;
  logic        trig;
  logic [25:0] dist_counter;
  logic        valid;
  logic        timeout;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int valid_hi = 0;
  int valid_cyc = 0;
  logic [31:0] last_dist = '0;
  logic [31:0] last_to = '0;

  range_sequencer #(
    .TRIG_CYCLES   (TRIG_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .echo        (echo),
    .trig        (trig),
    .dist_counter(dist_counter),
    .valid       (valid),
    .timeout     (timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every cycle valid is high, with the result it presents
  always @(negedge clk) begin
    if (valid) begin
      valid_hi  = valid_hi + 1;
      valid_cyc = cyc;
      last_dist = 32'(dist_counter);
      last_to   = 32'(timeout);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_trig_low(output int width);
    int g;
    width = 0;
    g = 0;
    while (trig && g < 100) begin
      width++;
      tick();
      g++;
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && g < 1000) begin
      tick();
      g++;
    end
    check("busy_wait", 32'(busy), 32'd0);
  endtask

  // One measurement: echo raised d cycles after trig falls, for w cycles (or never)
  task automatic meas(input int d, input int w, input bit noecho);
    int v0, tw;
    logic [31:0] exp_d, exp_t;
    v0 = valid_hi;
    if (noecho || w >= int'(TIMEOUT_CYCLES)) begin
      exp_d = SAT;
      exp_t = 32'd1;
    end else begin
      exp_d = 32'(w);
      exp_t = 32'd0;
    end
    do_start();
    wait_trig_low(tw);
    check("trig_width", 32'(tw), 32'(TRIG_CYCLES));
    if (!noecho) begin
      repeat (d) tick();
      echo = 1'b1;
      repeat (w) tick();
      echo = 1'b0;
    end
    wait_idle();
    check("valid_count", 32'(valid_hi - v0), 32'd1);
    check("dist", last_dist, exp_d);
    check("timeout", last_to, exp_t);
    check("dist_hold", 32'(dist_counter), exp_d);
    if (noecho || w < int'(TIMEOUT_CYCLES))
      check("holdoff_len", 32'(cyc - valid_cyc), 32'(HOLDOFF_CYCLES));
    repeat (3) tick();
  endtask

  initial begin
    int v0, tw, g;
    rst = 1'b1;
    start = 1'b0;
    echo = 1'b0;
    repeat (3) tick();
    check("rst_trig", 32'(trig), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dist", 32'(dist_counter), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    rst = 1'b0;
    repeat (20) tick();
    check("idle_trig", 32'(trig), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_dist", 32'(dist_counter), 32'd0);
    check("idle_valid_hi", 32'(valid_hi), 32'd0);

`ifdef RANGE_AUTO_RETRIGGER_EN
    // Continuous ranging: answer each trigger with a 15-cycle echo
    for (int i = 0; i < 3; i++) begin
      v0 = valid_hi;
      g = 0;
      while (!trig && g < 100) begin
        tick();
        g++;
      end
      wait_trig_low(tw);
      check("auto_trig_width", 32'(tw), 32'(TRIG_CYCLES));
      repeat (5) tick();
      echo = 1'b1;
      repeat (15) tick();
      echo = 1'b0;
      g = 0;
      while (valid_hi == v0 && g < 200) begin
        tick();
        g++;
      end
      check("auto_valid", 32'(valid_hi - v0), 32'd1);
      check("auto_dist", last_dist, 32'd15);
      check("auto_timeout", last_to, 32'd0);
    end
`else
    // Directed boundary cases first, then randomized pulses
    meas(5, 37, 1'b0);
    meas(0, 0, 1'b1);
    meas(4, 150, 1'b0);
    meas(4, 20, 1'b0);
    meas(3, 99, 1'b0);
    meas(3, 100, 1'b0);
    meas(2, 1, 1'b0);
    for (int i = 0; i < 6; i++)
      meas(int'($urandom_range(2, 60)), int'($urandom_range(1, 130)), 1'b0);

    // Reset in the middle of an echo: no result, everything cleared
    v0 = valid_hi;
    do_start();
    wait_trig_low(tw);
    repeat (3) tick();
    echo = 1'b1;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    check("midrst_trig", 32'(trig), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_dist", 32'(dist_counter), 32'd0);
    rst = 1'b0;
    repeat (5) tick();
    echo = 1'b0;
    repeat (30) tick();
    check("midrst_no_valid", 32'(valid_hi - v0), 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);

    // start during holdoff must not queue a new measurement
    v0 = valid_hi;
    do_start();
    wait_trig_low(tw);
    repeat (3) tick();
    echo = 1'b1;
    repeat (20) tick();
    echo = 1'b0;
    g = 0;
    while (valid_hi == v0 && g < 200) begin
      tick();
      g++;
    end
    tick();
    do_start();
    wait_idle();
    repeat (20) tick();
    check("hold_start_busy", 32'(busy), 32'd0);
    check("hold_start_trig", 32'(trig), 32'd0);
    check("hold_start_valid", 32'(valid_hi - v0), 32'd1);
    check("hold_start_dist", 32'(dist_counter), 32'd20);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
